// File: rtl/ro_scheduler_pkg.sv
// Shared definitions for the readout slot scheduler: the run/hold
// control encoding and the trailing-ones decode that picks the slot owner.
package ro_scheduler_pkg;

  localparam int MAX_CORES  = 16;
  localparam int SLOT_IDX_W = 5;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  // Number of trailing ones among the low 'width' bits of value, which is
  // also the index of the Gray bit that toggles when value increments.
  // A value that is all ones over 'width' bits returns 'width' (idle slot).
  function automatic logic [SLOT_IDX_W-1:0] trailing_ones(
    input logic [MAX_CORES-1:0] value,
    input int                   width
  );
    logic [SLOT_IDX_W-1:0] count;
    count = SLOT_IDX_W'(width);
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      if (i < width && !value[i]) count = SLOT_IDX_W'(i);
    end
    return count;
  endfunction

endpackage

// File: rtl/ro_slot_counter.sv
// Binary slot counter with registered Gray output. The slot owner for the
// current cycle is the Gray bit that flips on the next increment.
module ro_slot_counter
  import ro_scheduler_pkg::*;
#(
  parameter int NUM_CORES = 8,
  parameter int SLOT_W    = 3
) (
  input  logic                 clk_master,
  input  logic                 rstb,
  input  logic                 advance,
  output logic                 slot_idle,
  output logic [SLOT_W-1:0]    slot_index,
  output logic [NUM_CORES-1:0] gray_count
);

  logic [NUM_CORES-1:0]  count;
  logic [NUM_CORES-1:0]  count_next;
  logic [MAX_CORES-1:0]  padded;
  logic [SLOT_IDX_W-1:0] ones;

  // Decode the slot owner from the pre-increment count.
  always_comb begin
    padded                  = '0;
    padded[NUM_CORES-1:0]   = count;
    ones                    = trailing_ones(padded, NUM_CORES);
    count_next              = count + NUM_CORES'(1);
    slot_idle               = (ones == SLOT_IDX_W'(NUM_CORES));
    slot_index              = slot_idle ? '0 : ones[SLOT_W-1:0];
  end

  // Advance the counter and its Gray image together so they never disagree.
  always_ff @(posedge clk_master) begin
    if (!rstb) begin
      count      <= '0;
      gray_count <= '0;
    end else if (advance) begin
      count      <= count_next;
      gray_count <= count_next ^ (count_next >> 1);
    end
  end

endmodule

// File: rtl/ro_scheduler.sv
// Gray-code TDM readout scheduler: cores share one event bus, core k owning
// every 2^(k+1)-th slot. Events are held pending until their core's slot,
// and a second event arriving on a still-pending bit flags an overrun.
module ro_scheduler
  import ro_scheduler_pkg::*;
#(
  parameter int NUM_CORES = 8,
  parameter int SLOT_W    = 3
) (
  input  logic                 clk_master,
  input  logic                 rstb,
  input  logic                 enable,
  input  logic                 clear_overrun,
  input  logic [NUM_CORES-1:0] in_eve,
  input  logic [NUM_CORES-1:0] in_pol_eve,
  output logic                 out_eve,
  output logic                 out_pol_eve,
  output logic                 slot_valid,
  output logic [SLOT_W-1:0]    slot_id,
  output logic                 frame_start,
  output logic [NUM_CORES-1:0] gray_count,
  output logic [NUM_CORES-1:0] overrun
);

  ctrl_state_t          state;
  ctrl_state_t          next_state;
  logic                 advance;
  logic                 slot_idle;
  logic [SLOT_W-1:0]    slot_index;
  logic [NUM_CORES-1:0] pend_eve;
  logic [NUM_CORES-1:0] pend_pol_eve;
  logic [NUM_CORES-1:0] grant_mask;
  logic [NUM_CORES-1:0] next_pend_eve;
  logic [NUM_CORES-1:0] next_pend_pol_eve;
  logic [NUM_CORES-1:0] next_overrun;
  logic                 next_slot_valid;
  logic [SLOT_W-1:0]    next_slot_id;
  logic                 next_frame_start;
  logic                 next_out_eve;
  logic                 next_out_pol_eve;

  ro_slot_counter #(
    .NUM_CORES (NUM_CORES),
    .SLOT_W    (SLOT_W)
  ) u_slot_counter (
    .clk_master (clk_master),
    .rstb       (rstb),
    .advance    (advance),
    .slot_idle  (slot_idle),
    .slot_index (slot_index),
    .gray_count (gray_count)
  );

  // Run/hold control plus the grant, pending and overrun decisions for this edge.
  always_comb begin
    next_state = state;
    case (state)
      HOLD:    if (enable)  next_state = RUN;
      RUN:     if (!enable) next_state = HOLD;
      default: next_state = HOLD;
    endcase
    advance           = (next_state == RUN);
    next_slot_valid   = advance && !slot_idle;
    next_slot_id      = next_slot_valid ? slot_index : '0;
    next_frame_start  = advance && slot_idle;
    grant_mask        = next_slot_valid ? (NUM_CORES'(1) << slot_index) : '0;
    next_out_eve      = |((pend_eve | in_eve) & grant_mask);
    next_out_pol_eve  = |((pend_pol_eve | in_pol_eve) & grant_mask);
    next_pend_eve     = (pend_eve | in_eve) & ~grant_mask;
    next_pend_pol_eve = (pend_pol_eve | in_pol_eve) & ~grant_mask;
    next_overrun      = (overrun & ~{NUM_CORES{clear_overrun}})
                      | (((in_eve & pend_eve) | (in_pol_eve & pend_pol_eve)) & ~grant_mask);
  end

  // Register control state, pending events, overrun flags and bus outputs.
  always_ff @(posedge clk_master) begin
    if (!rstb) begin
      state        <= HOLD;
      pend_eve     <= '0;
      pend_pol_eve <= '0;
      overrun      <= '0;
      slot_valid   <= 1'b0;
      slot_id      <= '0;
      frame_start  <= 1'b0;
      out_eve      <= 1'b0;
      out_pol_eve  <= 1'b0;
    end else begin
      state        <= next_state;
      pend_eve     <= next_pend_eve;
      pend_pol_eve <= next_pend_pol_eve;
      overrun      <= next_overrun;
      slot_valid   <= next_slot_valid;
      slot_id      <= next_slot_id;
      frame_start  <= next_frame_start;
      out_eve      <= next_out_eve;
      out_pol_eve  <= next_pol_eve_sel();
    end
  end

  function automatic logic next_pol_eve_sel();
    return next_out_pol_eve;
  endfunction

endmodule

// File: tb/tb_ro_scheduler.sv
// Testbench for ro_scheduler with four cores: directed scenarios and random
// traffic checked against a frame-level model of the slot schedule.
module tb_ro_scheduler;

  localparam int NC = 4;
  localparam int SW = 2;
  localparam int FRAME = 16;

  logic          clk_master = 1'b0;
  logic          rstb = 1'b0;
  logic          enable = 1'b0;
  logic          clear_overrun = 1'b0;
  logic [NC-1:0] in_eve = '0;
  logic [NC-1:0] in_pol_eve = '0;
  logic          out_eve;
  logic          out_pol_eve;
  logic          slot_valid;
  logic [SW-1:0] slot_id;
  logic          frame_start;
  logic [NC-1:0] gray_count;
  logic [NC-1:0] overrun;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state
  int mb;
  bit pe [NC];
  bit pp [NC];
  bit ov [NC];
  bit exp_eve, exp_pol, exp_valid, exp_frame;
  int exp_id;
  int exp_gray;

  ro_scheduler #(.NUM_CORES(NC), .SLOT_W(SW)) dut (
    .clk_master    (clk_master),
    .rstb          (rstb),
    .enable        (enable),
    .clear_overrun (clear_overrun),
    .in_eve        (in_eve),
    .in_pol_eve    (in_pol_eve),
    .out_eve       (out_eve),
    .out_pol_eve   (out_pol_eve),
    .slot_valid    (slot_valid),
    .slot_id       (slot_id),
    .frame_start   (frame_start),
    .gray_count    (gray_count),
    .overrun       (overrun)
  );

  always #5 clk_master = ~clk_master;

  task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    logic [NC-1:0] ov_vec;
    for (int i = 0; i < NC; i++) ov_vec[i] = ov[i];
    checkValue("out_eve",     16'(out_eve),     16'(exp_eve));
    checkValue("out_pol_eve", 16'(out_pol_eve), 16'(exp_pol));
    checkValue("slot_valid",  16'(slot_valid),  16'(exp_valid));
    checkValue("slot_id",     16'(slot_id),     16'(exp_id));
    checkValue("frame_start", 16'(frame_start), 16'(exp_frame));
    checkValue("gray_count",  16'(gray_count),  16'(exp_gray));
    checkValue("overrun",     16'(overrun),     16'(ov_vec));
  endtask

  // Drive one cycle of inputs, predict the edge outcome, then check it.
  task automatic applyStimulus(input bit rst_n, input bit en, input bit clr,
                               input logic [NC-1:0] ev, input logic [NC-1:0] pol);
    int grant;
    bit idle;
    bit set;
    @(negedge clk_master);
    rstb = rst_n; enable = en; clear_overrun = clr; in_eve = ev; in_pol_eve = pol;
    if (!rst_n) begin
      mb = 0;
      for (int i = 0; i < NC; i++) begin pe[i] = 0; pp[i] = 0; ov[i] = 0; end
      exp_eve = 0; exp_pol = 0; exp_valid = 0; exp_frame = 0; exp_id = 0; exp_gray = 0;
    end else begin
      grant = -1;
      idle  = 0;
      if (en) begin
        int k = 0;
        while (k < NC && ((mb >> k) & 1) == 1) k++;
        if (k == NC) idle = 1; else grant = k;
      end
      exp_valid = (grant >= 0);
      exp_id    = (grant >= 0) ? grant : 0;
      exp_frame = en && idle;
      exp_eve   = 0;
      exp_pol   = 0;
      for (int i = 0; i < NC; i++) begin
        if (i == grant) begin
          exp_eve = pe[i] | ev[i];
          exp_pol = pp[i] | pol[i];
          pe[i] = 0; pp[i] = 0;
          set = 0;
        end else begin
          set = (ev[i] && pe[i]) || (pol[i] && pp[i]);
          pe[i] = pe[i] | ev[i];
          pp[i] = pp[i] | pol[i];
        end
        ov[i] = (ov[i] && !clr) || set;
      end
      if (en) begin
        mb = (mb + 1) % FRAME;
        exp_gray = mb ^ (mb >> 1);
      end
    end
    @(posedge clk_master);
    #1;
    checkOutput();
  endtask

  initial begin
    int seq [FRAME] = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 0};
    logic [NC-1:0] ev, pol;

    // Reset state
    applyStimulus(0, 1, 1, '1, '1);
    applyStimulus(0, 0, 0, '0, '0);

    // Idle-bus slot order across two frames, independent of the model
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        applyStimulus(1, 1, 0, '0, '0);
        checkValue("seq_slot_id",     16'(slot_id),     16'(seq[i]));
        checkValue("seq_frame_start", 16'(frame_start), 16'(i == FRAME - 1));
      end
    end

    // Core 2 event at cycle 5: delivered once at the next core-2 slot
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, '0, '0);
    applyStimulus(1, 1, 0, 4'b0100, '0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, '0, '0);

    // Two core-3 events before its slot: overrun, single delivery, then clear
    while (mb != 8) applyStimulus(1, 1, 0, '0, '0);
    applyStimulus(1, 1, 0, 4'b1000, '0);
    applyStimulus(1, 1, 0, '0, '0);
    applyStimulus(1, 1, 0, 4'b1000, '0);
    checkValue("overrun3_set", 16'(overrun[3]), 16'd1);
    for (int i = 0; i < FRAME; i++) applyStimulus(1, 1, 0, '0, '0);
    applyStimulus(1, 1, 1, '0, '0);
    checkValue("overrun3_clear", 16'(overrun[3]), 16'd0);

    // Polarity event coincident with a core-0 grant
    while ((mb % 2) != 0) applyStimulus(1, 1, 0, '0, '0);
    applyStimulus(1, 1, 0, '0, 4'b0001);
    checkValue("pol0_same_slot", 16'(out_pol_eve), 16'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, '0, '0);

    // Hold for ten cycles mid-frame, then resume
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, '0, '0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, (i == 4) ? 4'b0010 : 4'b0000, '0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, '0, '0);

    // Random traffic with occasional hold, clear and reset
    for (int i = 0; i < 400; i++) begin
      ev  = '0;
      pol = '0;
      for (int c = 0; c < NC; c++) begin
        ev[c]  = ($urandom_range(0, 7) == 0);
        pol[c] = ($urandom_range(0, 9) == 0);
      end
      applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 19) == 0), ev, pol);
    end

    // Reset mid-frame discards pending events
    applyStimulus(1, 1, 0, '0, '0);
    applyStimulus(1, 1, 0, 4'b1111, 4'b1111);
    applyStimulus(0, 1, 0, '0, '0);
    applyStimulus(1, 1, 0, '0, '0);
    checkValue("post_reset_slot", 16'(slot_id), 16'd0);
    checkValue("post_reset_eve",  16'(out_eve), 16'd0);
    for (int i = 0; i < FRAME; i++) applyStimulus(1, 1, 0, '0, '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
